lc3_decode_stage: RTL

- Decode pipeline stage of the LC3 core; sink end of the decode_in signal bundle.
- Captures the fetched instruction (dout) and next-PC (npc_in) when enable_decode is high.
- Drives registered IR, npc_out and the execute, writeback and memory control words to the execute stage.
- One-cycle latency; holds its last decode while enable_decode is low.

---
 rtl/lc3_decode_pkg.sv | 46 ++++
 rtl/lc3_ctrl_gen.sv | 87 ++++++++
 rtl/lc3_decode_stage.sv | 74 +++++++
 3 files changed

// File: rtl/lc3_decode_pkg.sv
// rtl/lc3_decode_pkg.sv - LC3 decode opcodes, control encodings, field offsets and helpers
package lc3_decode_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RES  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_AND   = 2'b01;
    localparam logic [1:0] ALU_NOT   = 2'b10;

    localparam logic [1:0] PCS1_NONE = 2'b00;
    localparam logic [1:0] PCS1_OFF9 = 2'b01;
    localparam logic [1:0] PCS1_OFF6 = 2'b10;
    localparam logic [1:0] PCS1_ZERO = 2'b11;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
    localparam logic [1:0] WB_NONE   = 2'b00;

    localparam int E_ALU_LSB  = 4;
    localparam int E_PCS1_LSB = 2;
    localparam int E_PCS2_BIT = 1;
    localparam int E_OP2_BIT  = 0;

    function automatic logic is_supported_opcode(input logic [3:0] op);
        return !(op inside {OP_JSR, OP_RTI, OP_RES, OP_TRAP});
    endfunction

endpackage

// File: rtl/lc3_ctrl_gen.sv
// rtl/lc3_ctrl_gen.sv - combinational map from {opcode, ir5} to execute/writeback/memory controls
module lc3_ctrl_gen
    import lc3_decode_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       ir5,
    output logic [5:0] e_control,
    output logic [1:0] w_control,
    output logic       mem_control
);

    opcode_e op;
    assign op = opcode_e'(opcode);

    // decode each control field from the opcode; unsupported opcodes keep all-zero defaults
    always_comb begin
        logic [1:0] alu;
        logic [1:0] pcs1;
        logic       pcs2;
        logic       op2;
        alu         = ALU_ADD;
        pcs1        = PCS1_NONE;
        pcs2        = 1'b0;
        op2         = 1'b0;
        w_control   = WB_NONE;
        mem_control = 1'b0;
        e_control   = '0;
        case (op)
            OP_ADD: begin
                alu       = ALU_ADD;
                op2       = ~ir5;
                w_control = WB_ALU;
            end
            OP_AND: begin
                alu       = ALU_AND;
                op2       = ~ir5;
                w_control = WB_ALU;
            end
            OP_NOT: begin
                alu       = ALU_NOT;
                w_control = WB_ALU;
            end
            OP_BR, OP_ST: begin
                pcs1 = PCS1_OFF9;
                pcs2 = 1'b1;
            end
            OP_LD: begin
                pcs1      = PCS1_OFF9;
                pcs2      = 1'b1;
                w_control = WB_MEM;
            end
            OP_LDI: begin
                pcs1        = PCS1_OFF9;
                pcs2        = 1'b1;
                w_control   = WB_MEM;
                mem_control = 1'b1;
            end
            OP_STI: begin
                pcs1        = PCS1_OFF9;
                pcs2        = 1'b1;
                mem_control = 1'b1;
            end
            OP_LEA: begin
                pcs1      = PCS1_OFF9;
                pcs2      = 1'b1;
                w_control = WB_PC;
            end
            OP_LDR: begin
                pcs1      = PCS1_OFF6;
                w_control = WB_MEM;
            end
            OP_STR: begin
                pcs1 = PCS1_OFF6;
            end
            OP_JMP: begin
                pcs1 = PCS1_ZERO;
            end
            default: begin
            end
        endcase
        e_control[E_ALU_LSB +: 2]  = alu;
        e_control[E_PCS1_LSB +: 2] = pcs1;
        e_control[E_PCS2_BIT]      = pcs2;
        e_control[E_OP2_BIT]       = op2;
    end

endmodule

// File: rtl/lc3_decode_stage.sv
// rtl/lc3_decode_stage.sv - LC3 decode stage registers; LC3_DECODE_ILLEGAL_CHECK_EN adds illegal_op
module lc3_decode_stage
    import lc3_decode_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int E_CTRL_W = 6,
    parameter int W_CTRL_W = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_decode,
    input  logic [DATA_W-1:0]   dout,
    input  logic [DATA_W-1:0]   npc_in,
    output logic [DATA_W-1:0]   IR,
    output logic [DATA_W-1:0]   npc_out,
    output logic [E_CTRL_W-1:0] E_Control,
    output logic [W_CTRL_W-1:0] W_Control,
    output logic                Mem_Control,
    output logic                decode_valid
`ifdef LC3_DECODE_ILLEGAL_CHECK_EN
    ,
    output logic                illegal_op
`endif
);

    if (DATA_W != 16 || E_CTRL_W != 6 || W_CTRL_W != 2) begin : g_bad_params
        $error("lc3_decode_stage supports only DATA_W=16, E_CTRL_W=6, W_CTRL_W=2");
    end

    logic [5:0] e_next;
    logic [1:0] w_next;
    logic       m_next;

    lc3_ctrl_gen u_ctrl_gen (
        .opcode      (dout[15:12]),
        .ir5         (dout[5]),
        .e_control   (e_next),
        .w_control   (w_next),
        .mem_control (m_next)
    );

    // capture instruction, next PC and fresh controls on enabled edges; hold otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            IR           <= '0;
            npc_out      <= '0;
            E_Control    <= '0;
            W_Control    <= '0;
            Mem_Control  <= 1'b0;
            decode_valid <= 1'b0;
        end else begin
            decode_valid <= enable_decode;
            if (enable_decode) begin
                IR          <= dout;
                npc_out     <= npc_in;
                E_Control   <= e_next;
                W_Control   <= w_next;
                Mem_Control <= m_next;
            end
        end
    end

`ifdef LC3_DECODE_ILLEGAL_CHECK_EN
    // flag unsupported opcodes on each enabled edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            illegal_op <= 1'b0;
        end else if (enable_decode) begin
            illegal_op <= !is_supported_opcode(dout[15:12]);
        end
    end
`endif

endmodule
